// File: rtl/charge_compute_pkg.sv
// Shared types and constants for the charging-station payment engine.
package charge_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      SELECT = 2'b01,
      CHARGE = 2'b10,
      DONE   = 2'b11
   } state_t;

   localparam int unsigned MAX_AMOUNT_DEF = 20;
   localparam int unsigned BAL_W          = 7;

endpackage

// File: rtl/charge_compute_if.sv
// Key/cancel inputs and display/status outputs between controller and charge engine.
interface charge_compute_if;

   logic       card_in;
   logic       one;
   logic       ten;
   logic       start;
   logic       cancel_flag;
   logic       charging;
   logic       fin;
   logic [7:0] balance_bcd;
   logic [1:0] st;

   modport master (
      output card_in, one, ten, start, cancel_flag,
      input  charging, fin, balance_bcd, st
   );

   modport slave (
      input  card_in, one, ten, start, cancel_flag,
      output charging, fin, balance_bcd, st
   );

endinterface

// File: rtl/charge_compute_sec_tick.sv
// One-second prescaler: single-cycle tick at terminal count, restartable via clr.
module sec_tick #(
   parameter int unsigned TICK_DIV = 100000000
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   output logic tick
);

   localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] r_cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cnt <= '0;
      end else if (clr || (r_cnt == LAST)) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   // Not gated by clr: clr is derived from next-state, which itself consumes tick.
   assign tick = (r_cnt == LAST);

endmodule

// File: rtl/charge_compute.sv
// Payment/charging engine: accumulates paid balance, counts it down while charging.
module charge_compute
   import charge_pkg::*;
#(
   parameter int unsigned TICK_DIV     = 100000000,
   parameter int unsigned SEC_PER_UNIT = 2,
   parameter int unsigned MAX_AMOUNT   = MAX_AMOUNT_DEF,
   parameter int unsigned SEL_TIMEOUT  = 10,
   parameter int unsigned DONE_HOLD    = 3
) (
   input  logic             clk,
   input  logic             reset,
   charge_compute_if.slave  bus
);

   localparam int unsigned SEC_MAX =
      (SEL_TIMEOUT > DONE_HOLD)
         ? ((SEL_TIMEOUT > SEC_PER_UNIT) ? SEL_TIMEOUT : SEC_PER_UNIT)
         : ((DONE_HOLD   > SEC_PER_UNIT) ? DONE_HOLD   : SEC_PER_UNIT);
   localparam int unsigned SEC_W = $clog2(SEC_MAX + 1);

   localparam logic [BAL_W-1:0] ONE_U = BAL_W'(1);
   localparam logic [BAL_W-1:0] TEN_U = BAL_W'(10);
   localparam logic [BAL_W-1:0] MAX_U = BAL_W'(MAX_AMOUNT);
   localparam logic [SEC_W-1:0] SPU_LAST = SEC_W'(SEC_PER_UNIT - 1);
   localparam logic [SEC_W-1:0] SEL_LAST = SEC_W'(SEL_TIMEOUT - 1);
   localparam logic [SEC_W-1:0] DH_LAST  = SEC_W'(DONE_HOLD - 1);

   state_t           r_state, w_state_nxt;
   logic [BAL_W-1:0] r_balance, w_balance_nxt, w_sum;
   logic [SEC_W-1:0] r_sec, w_sec_nxt;
   logic             r_charging, r_fin;
   logic [7:0]       r_bcd;
   logic             w_tick, w_clr;

   sec_tick #(.TICK_DIV(TICK_DIV)) u_sec_tick (
      .clk   (clk),
      .reset (reset),
      .clr   (w_clr),
      .tick  (w_tick)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= IDLE;
         r_balance  <= '0;
         r_sec      <= '0;
         r_charging <= 1'b0;
         r_fin      <= 1'b0;
         r_bcd      <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_balance  <= w_balance_nxt;
         r_sec      <= w_sec_nxt;
         r_charging <= (w_state_nxt == CHARGE);
         r_fin      <= (w_state_nxt == DONE) && (r_state != DONE);
         r_bcd      <= {4'(r_balance / TEN_U), 4'(r_balance % TEN_U)};
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_balance_nxt = r_balance;
      w_sec_nxt     = r_sec;
      w_sum         = r_balance + (bus.one ? ONE_U : '0) + (bus.ten ? TEN_U : '0);
      unique case (r_state)
         IDLE: begin
            w_balance_nxt = '0;
            if (bus.card_in) w_state_nxt = SELECT;
         end
         SELECT: begin
            if (!bus.card_in || bus.cancel_flag) begin
               w_state_nxt   = IDLE;
               w_balance_nxt = '0;
            end else if (bus.start && (r_balance != '0)) begin
               w_state_nxt = CHARGE;
            end else if (bus.one || bus.ten) begin
               w_balance_nxt = (w_sum > MAX_U) ? MAX_U : w_sum;
               w_sec_nxt     = '0;
            end else if (w_tick) begin
               if (r_sec == SEL_LAST) begin
                  w_state_nxt   = IDLE;
                  w_balance_nxt = '0;
               end else begin
                  w_sec_nxt = r_sec + 1'b1;
               end
            end
         end
         CHARGE: begin
            if (!bus.card_in || bus.cancel_flag) begin
               w_state_nxt = DONE;
            end else if (w_tick) begin
               if (r_sec == SPU_LAST) begin
                  w_balance_nxt = r_balance - 1'b1;
                  w_sec_nxt     = '0;
                  if (r_balance == ONE_U) w_state_nxt = DONE;
               end else begin
                  w_sec_nxt = r_sec + 1'b1;
               end
            end
         end
         DONE: begin
            // r_fin marks the first DONE cycle, where a card drop is not yet honoured.
            if ((!bus.card_in && !r_fin) || (w_tick && (r_sec == DH_LAST))) begin
               w_state_nxt   = IDLE;
               w_balance_nxt = '0;
            end else if (w_tick) begin
               w_sec_nxt = r_sec + 1'b1;
            end
         end
      endcase
      if (w_state_nxt != r_state) w_sec_nxt = '0;
   end

   assign w_clr = (w_state_nxt != r_state);

   assign bus.charging    = r_charging;
   assign bus.fin         = r_fin;
   assign bus.balance_bcd = r_bcd;
   assign bus.st          = r_state;

endmodule

// File: tb/tb_charge_compute.sv
// Directed self-checking bench for charge_compute with a 10-cycle tick.
module tb_charge_compute;

   logic clk;
   logic reset;
   int   n_checks;
   int   n_fail;

   charge_compute_if bus ();

   charge_compute #(
      .TICK_DIV     (10),
      .SEC_PER_UNIT (2),
      .MAX_AMOUNT   (20),
      .SEL_TIMEOUT  (10),
      .DONE_HOLD    (3)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      bus.card_in     = 1'b0;
      bus.one         = 1'b0;
      bus.ten         = 1'b0;
      bus.start       = 1'b0;
      bus.cancel_flag = 1'b0;
   endtask

   task automatic do_reset();
      clear_inputs();
      reset = 1'b0;
      cyc(2);
      reset = 1'b1;
      cyc(1);
   endtask

   task automatic press_one();
      bus.one = 1'b1;
      cyc(1);
      bus.one = 1'b0;
   endtask

   task automatic press_ten();
      bus.ten = 1'b1;
      cyc(1);
      bus.ten = 1'b0;
   endtask

   task automatic test_reset();
      clear_inputs();
      reset = 1'b0;
      cyc(2);
      n_checks++;
      if (bus.st !== 2'b00) begin n_fail++; $display("FAIL reset_st: got %b expected 00", bus.st); end
      n_checks++;
      if (bus.balance_bcd !== 8'h00) begin n_fail++; $display("FAIL reset_bcd: got %h expected 00", bus.balance_bcd); end
      n_checks++;
      if (bus.charging !== 1'b0 || bus.fin !== 1'b0) begin
         n_fail++; $display("FAIL reset_flags: got charging=%b fin=%b expected 0 0", bus.charging, bus.fin);
      end
      reset = 1'b1;
      cyc(1);
      // get into CHARGE, then reset asynchronously
      bus.card_in = 1'b1;
      cyc(1);
      press_one();
      press_one();
      press_one();
      bus.start = 1'b1;
      cyc(1);
      bus.start = 1'b0;
      cyc(5);
      n_checks++;
      if (bus.charging !== 1'b1) begin n_fail++; $display("FAIL pre_reset_charging: got %b expected 1", bus.charging); end
      reset = 1'b0;
      bus.card_in = 1'b0;
      #1;
      n_checks++;
      if (bus.st !== 2'b00 || bus.charging !== 1'b0 || bus.fin !== 1'b0 || bus.balance_bcd !== 8'h00) begin
         n_fail++;
         $display("FAIL mid_reset: got st=%b charging=%b fin=%b bcd=%h expected 00 0 0 00",
                  bus.st, bus.charging, bus.fin, bus.balance_bcd);
      end
      cyc(2);
      n_checks++;
      if (bus.fin !== 1'b0) begin n_fail++; $display("FAIL mid_reset_fin: got %b expected 0", bus.fin); end
      reset = 1'b1;
      bus.card_in = 1'b1;
      cyc(1);
      n_checks++;
      if (bus.st !== 2'b01) begin n_fail++; $display("FAIL entry_select: got %b expected 01", bus.st); end
   endtask

   task automatic test_accumulate();
      do_reset();
      bus.card_in = 1'b1;
      cyc(1);
      press_ten();
      press_one();
      press_one();
      cyc(1);
      n_checks++;
      if (bus.balance_bcd !== 8'h12) begin n_fail++; $display("FAIL acc_12: got %h expected 12", bus.balance_bcd); end
      press_ten();
      cyc(1);
      n_checks++;
      if (bus.balance_bcd !== 8'h20) begin n_fail++; $display("FAIL acc_sat20: got %h expected 20", bus.balance_bcd); end
      press_one();
      cyc(1);
      n_checks++;
      if (bus.balance_bcd !== 8'h20) begin n_fail++; $display("FAIL acc_clamp: got %h expected 20", bus.balance_bcd); end
      bus.card_in = 1'b0;
      cyc(1);
      bus.card_in = 1'b1;
      cyc(1);
      bus.one = 1'b1;
      bus.ten = 1'b1;
      cyc(1);
      bus.one = 1'b0;
      bus.ten = 1'b0;
      cyc(1);
      n_checks++;
      if (bus.balance_bcd !== 8'h11 || bus.st !== 2'b01) begin
         n_fail++; $display("FAIL acc_both: got bcd=%h st=%b expected 11 01", bus.balance_bcd, bus.st);
      end
   endtask

   task automatic test_full_charge();
      do_reset();
      bus.card_in = 1'b1;
      cyc(1);
      press_one();
      press_one();
      press_one();
      bus.start = 1'b1;
      cyc(1);
      bus.start = 1'b0;
      n_checks++;
      if (bus.charging !== 1'b1 || bus.st !== 2'b10 || bus.balance_bcd !== 8'h03) begin
         n_fail++;
         $display("FAIL chg_entry: got charging=%b st=%b bcd=%h expected 1 10 03", bus.charging, bus.st, bus.balance_bcd);
      end
      cyc(20);
      n_checks++;
      if (bus.balance_bcd !== 8'h03) begin n_fail++; $display("FAIL chg_hold3: got %h expected 03", bus.balance_bcd); end
      cyc(1);
      n_checks++;
      if (bus.balance_bcd !== 8'h02) begin n_fail++; $display("FAIL chg_step2: got %h expected 02", bus.balance_bcd); end
      cyc(19);
      n_checks++;
      if (bus.balance_bcd !== 8'h02) begin n_fail++; $display("FAIL chg_hold2: got %h expected 02", bus.balance_bcd); end
      cyc(1);
      n_checks++;
      if (bus.balance_bcd !== 8'h01) begin n_fail++; $display("FAIL chg_step1: got %h expected 01", bus.balance_bcd); end
      cyc(18);
      n_checks++;
      if (bus.fin !== 1'b0 || bus.st !== 2'b10) begin
         n_fail++; $display("FAIL chg_before_done: got fin=%b st=%b expected 0 10", bus.fin, bus.st);
      end
      cyc(1);
      n_checks++;
      if (bus.fin !== 1'b1 || bus.st !== 2'b11 || bus.charging !== 1'b0) begin
         n_fail++;
         $display("FAIL chg_done_entry: got fin=%b st=%b charging=%b expected 1 11 0", bus.fin, bus.st, bus.charging);
      end
      cyc(1);
      n_checks++;
      if (bus.fin !== 1'b0 || bus.balance_bcd !== 8'h00) begin
         n_fail++; $display("FAIL chg_fin_once: got fin=%b bcd=%h expected 0 00", bus.fin, bus.balance_bcd);
      end
      cyc(28);
      n_checks++;
      if (bus.st !== 2'b11) begin n_fail++; $display("FAIL done_hold: got %b expected 11", bus.st); end
      cyc(1);
      n_checks++;
      if (bus.st !== 2'b00) begin n_fail++; $display("FAIL done_exit: got %b expected 00", bus.st); end
   endtask

   task automatic test_cancel_charge();
      int fins;
      do_reset();
      bus.card_in = 1'b1;
      cyc(1);
      repeat (5) press_one();
      bus.start = 1'b1;
      cyc(1);
      bus.start = 1'b0;
      cyc(44);
      bus.cancel_flag = 1'b1;
      cyc(1);
      bus.cancel_flag = 1'b0;
      n_checks++;
      if (bus.st !== 2'b11 || bus.fin !== 1'b1) begin
         n_fail++; $display("FAIL cancel_done: got st=%b fin=%b expected 11 1", bus.st, bus.fin);
      end
      fins = 1;
      for (int i = 0; i < 20; i++) begin
         cyc(1);
         if (bus.fin === 1'b1) fins++;
      end
      n_checks++;
      if (fins !== 1) begin n_fail++; $display("FAIL cancel_fin_count: got %0d expected 1", fins); end
      n_checks++;
      if (bus.balance_bcd !== 8'h03 || bus.st !== 2'b11) begin
         n_fail++; $display("FAIL cancel_refund: got bcd=%h st=%b expected 03 11", bus.balance_bcd, bus.st);
      end
   endtask

   task automatic test_select_guards();
      do_reset();
      bus.card_in = 1'b1;
      cyc(1);
      bus.start = 1'b1;
      cyc(1);
      bus.start = 1'b0;
      n_checks++;
      if (bus.st !== 2'b01 || bus.charging !== 1'b0) begin
         n_fail++; $display("FAIL start_zero: got st=%b charging=%b expected 01 0", bus.st, bus.charging);
      end
      press_one();
      cyc(97);
      n_checks++;
      if (bus.st !== 2'b01 || bus.balance_bcd !== 8'h01) begin
         n_fail++; $display("FAIL timeout_early: got st=%b bcd=%h expected 01 01", bus.st, bus.balance_bcd);
      end
      cyc(1);
      n_checks++;
      if (bus.st !== 2'b00) begin n_fail++; $display("FAIL timeout_idle: got %b expected 00", bus.st); end
      bus.card_in = 1'b0;
      cyc(1);
      n_checks++;
      if (bus.balance_bcd !== 8'h00) begin n_fail++; $display("FAIL timeout_bal: got %h expected 00", bus.balance_bcd); end
      bus.card_in = 1'b1;
      cyc(1);
      press_one();
      bus.card_in = 1'b0;
      cyc(1);
      n_checks++;
      if (bus.st !== 2'b00 || bus.fin !== 1'b0) begin
         n_fail++; $display("FAIL card_drop: got st=%b fin=%b expected 00 0", bus.st, bus.fin);
      end
   endtask

   task automatic test_simultaneous();
      int chg;
      do_reset();
      bus.card_in = 1'b1;
      cyc(1);
      press_one();
      press_one();
      bus.cancel_flag = 1'b1;
      bus.start       = 1'b1;
      chg = 0;
      cyc(1);
      bus.cancel_flag = 1'b0;
      bus.start       = 1'b0;
      if (bus.charging === 1'b1) chg++;
      n_checks++;
      if (bus.st !== 2'b00) begin n_fail++; $display("FAIL simul_idle: got %b expected 00", bus.st); end
      for (int i = 0; i < 5; i++) begin
         cyc(1);
         if (bus.charging === 1'b1) chg++;
      end
      n_checks++;
      if (chg !== 0) begin n_fail++; $display("FAIL simul_charging: got %0d cycles expected 0", chg); end
      n_checks++;
      if (bus.balance_bcd !== 8'h00) begin n_fail++; $display("FAIL simul_bal: got %h expected 00", bus.balance_bcd); end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      reset    = 1'b0;
      test_reset();
      test_accumulate();
      test_full_charge();
      test_cancel_charge();
      test_select_guards();
      test_simultaneous();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/charge_compute.md
Name: charge_compute

Overview:
- Payment/charging engine for the charging-station controller. Sits directly downstream of the top-level controller FSM.
- Once a card is held in, it accumulates the paid amount from the one/ten keys. On start, it counts the balance down at a fixed rate while charging.
- Raises fin when charging ends or is cancelled.
- Drives a BCD balance for the seven-segment display stage.

Parameters:
- TICK_DIV, 100000000: clk cycles per 1 s tick (simulation uses 10).
- SEC_PER_UNIT, 2: seconds of charging consumed per 1 unit of balance.
- MAX_AMOUNT, 20: balance saturation limit (must be <= 99).
- SEL_TIMEOUT, 10: seconds with no key activity in SELECT before abort.
- DONE_HOLD, 3: seconds DONE is held before returning to IDLE.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- card_in  in  1  level; card held in (hold_in from controller).
- one  in  1  single-cycle pulse, synchronous; add 1 unit.
- ten  in  1  single-cycle pulse, synchronous; add 10 units.
- start  in  1  single-cycle pulse; begin charging.
- cancel_flag  in  1  single-cycle pulse; abort selection or charging.
- charging  out  1  high throughout CHARGE.
- fin  out  1  one-cycle pulse on entry to DONE.
- balance_bcd  out  8  [7:4] tens, [3:0] ones of current balance.
- st  out  2  current state encoding (debug/LED).

Behaviour:
- Reset (async, reset=0):
  - state=IDLE, balance=0, prescaler=0, sec counter=0.
  - charging=0, fin=0, balance_bcd=8'h00, st=2'b00.
- All outputs are registered.
- balance_bcd reflects balance one cycle after balance changes.
- States: IDLE=00, SELECT=01, CHARGE=10, DONE=11.
- Tick: prescaler counts 0..TICK_DIV-1 and emits a 1-cycle tick at terminal count. The prescaler and sec counter clear on every state entry, so the first second after entry is full length.
- IDLE:
  - balance held at 0.
  - card_in=1 -> SELECT.
- SELECT, priority order (first matching rule wins):
  - card_in=0 or cancel_flag -> IDLE, balance=0.
  - start with balance>0 -> CHARGE. start with balance=0 is ignored.
  - one/ten: balance += 1 / 10. Both in the same cycle -> +11. Result clamps at MAX_AMOUNT.
  - Any key press, including one at saturation, clears the timeout counter.
  - SEL_TIMEOUT ticks with no key -> IDLE, balance=0.
- CHARGE:
  - charging=1.
  - The sec counter counts ticks. At SEC_PER_UNIT ticks, balance -= 1 and the counter clears.
  - When balance reaches 0 -> DONE.
  - cancel_flag or card_in=0 -> DONE immediately; the remaining balance is kept (refund shown).
  - one/ten/start are ignored.
  - A decrement and cancel in the same cycle: cancel wins; no decrement that cycle.
- DONE:
  - fin pulses in the first cycle only. balance is frozen.
  - After DONE_HOLD ticks, or when card_in=0 after the first cycle -> IDLE, balance cleared.
- Width: balance is 7 bits (covers 99+11 before clamp), computed unsigned.
- BCD: tens = balance/10, ones = balance%10. Only valid for balance <= 99 (guaranteed by MAX_AMOUNT).
- Reset mid-operation: immediately returns to the reset values. No fin pulse.

Decomposition:
- Shared package (charge_pkg):
  - state encodings IDLE/SELECT/CHARGE/DONE;
  - MAX_AMOUNT default;
  - the 7-bit balance width constant.
- Sub-module sec_tick:
  - parameter TICK_DIV; inputs clk, reset, clr; output tick;
  - instantiated once.
- The BCD split stays inline.

Test Plan:
- Reset/entry (TICK_DIV=10): reset low mid-CHARGE -> balance_bcd=00, st=00, charging=0, no fin. Then card_in=1 -> st=01 next cycle.
- Accumulate/saturate: ten, one, one (separate cycles) -> balance_bcd=8'h12. ten again -> 8'h20. Further one -> stays 8'h20. one+ten same cycle from 0 -> 8'h11.
- Full charge: balance 3, start -> charging=1. balance_bcd steps 03->02->01->00, each step 20 cycles apart (SEC_PER_UNIT=2, TICK_DIV=10). fin high exactly one cycle on entry to DONE. DONE_HOLD (30 cycles) later -> IDLE.
- Cancel while charging: balance 5, cancel_flag after 45 cycles -> DONE with balance_bcd=8'h03, single fin pulse, no further decrement.
- SELECT guards: start at balance 0 -> stays SELECT. 100 cycles (10 ticks) without a key -> IDLE, balance 0. card_in drop in SELECT -> IDLE next cycle, no fin.
- Simultaneous: cancel_flag and start in the same cycle in SELECT -> IDLE, balance cleared, charging never asserts.
